filter_inst_arbiter: RTL

- Round-robin, burst-locking arbiter that shares one NoC injection port among NREQ instruction generators (filter, ifmap and psum generators).
- Each generator emits bursts of WIDTH-bit instruction packets. Bit 14 = last-of-burst flag, bits 3:1 = index, bit 0 = packet type.
- Once a requester wins, it keeps the port until it sends a packet with the last flag set, so that bursts are never interleaved.
- The output is registered, so it can drive a router input port directly.

---
 rtl/filter_inst_pkg.sv | 14 +
 rtl/filter_inst_arbiter_if.sv | 26 ++
 rtl/filter_inst_arbiter_rr_pick.sv | 28 ++
 rtl/filter_inst_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/filter_inst_pkg.sv
// Shared types and packet field positions for the NoC instruction arbiters.
package filter_inst_pkg;

  localparam int PKT_W    = 15;
  localparam int LAST_BIT = 14;
  localparam int IDX_LSB  = 1;
  localparam int IDX_MSB  = 3;
  localparam int TYPE_BIT = 0;

  typedef enum logic {IDLE, LOCKED} arb_state_e;

  typedef logic [PKT_W-1:0] inst_pkt_t;

endpackage

// File: rtl/filter_inst_arbiter_if.sv
// Request/response bundle between the instruction generators and the arbiter.
// master = generator/downstream side, slave = arbiter side.
interface filter_inst_arbiter_if #(
  parameter int WIDTH = 15,
  parameter int NREQ  = 3,
  parameter int SRC_W = 3
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SRC_W-1:0]      out_src;
  logic                  out_ready;
  logic                  busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/filter_inst_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first set bit of vld
// at or after ptr (wrapping modulo N), plus a flag that any bit was set.
// ptr is expected to be < N.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     vld,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any
);

  // Scan offsets 0..N-1 from ptr; the first hit wins, later hits are masked.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && vld[j] && (((int'(ptr) + i) % N) == j)) begin
          grant = PTR_W'(j);
          any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/filter_inst_arbiter.sv
// filter_inst_arbiter: round-robin, burst-locking arbiter sharing one NoC
// injection port among NREQ instruction generators. Output is registered.
// Optional macro FILTER_INST_ARB_PERF_CNT_EN adds per-requester packet
// counters (pkt_cnt) and a completed-burst counter (burst_cnt).
module filter_inst_arbiter #(
  parameter int WIDTH    = filter_inst_pkg::PKT_W,
  parameter int NREQ     = 3,
  parameter int LAST_BIT = filter_inst_pkg::LAST_BIT,
  parameter int SRC_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  filter_inst_arbiter_if.slave bus
`ifdef FILTER_INST_ARB_PERF_CNT_EN
  ,
  output logic [NREQ*16-1:0]   pkt_cnt,
  output logic [15:0]          burst_cnt
`endif
);
  import filter_inst_pkg::*;

  arb_state_e                  state, state_nxt;
  logic [SRC_W-1:0]            rr_ptr, rr_nxt, lock_id, lock_nxt, pick, sel;
  logic                        any, can_load, sel_vld, accept, acc_last;
  logic [NREQ-1:0]             ready;
  logic [NREQ-1:0][WIDTH-1:0]  req_arr;
  logic [WIDTH-1:0]            acc_data;

  assign req_arr  = bus.req_data;
  // Output slot is free, or is being drained this cycle (out_ready -> req_ready path).
  assign can_load = !bus.out_valid || bus.out_ready;

  rr_pick #(.N(NREQ), .PTR_W(SRC_W)) u_pick (
    .vld   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick),
    .any   (any)
  );

  // Select the serviced requester: locked owner, else round-robin winner.
  always_comb begin
    sel      = (state == LOCKED) ? lock_id : pick;
    sel_vld  = 1'b0;
    acc_data = '0;
    ready    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == SRC_W'(i)) begin
        sel_vld  = bus.req_valid[i];
        acc_data = req_arr[i];
        ready[i] = can_load && rst_n;
      end
    end
    accept   = sel_vld && can_load;
    acc_last = acc_data[LAST_BIT];
  end

  assign bus.req_ready = ready;
  assign bus.busy      = (state == LOCKED);

  // Next state: lock on a non-last accept, release and rotate on a last accept.
  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_id;
    rr_nxt    = rr_ptr;
    if (accept) begin
      if (acc_last) begin
        state_nxt = IDLE;
        rr_nxt    = (sel == SRC_W'(NREQ-1)) ? '0 : sel + 1'b1;
      end else if (state == IDLE) begin
        state_nxt = LOCKED;
        lock_nxt  = sel;
      end
    end
  end

  // FSM and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_id <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      lock_id <= lock_nxt;
      rr_ptr  <= rr_nxt;
    end
  end

  // Output register: load on accept, drop valid when drained, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= acc_data;
      bus.out_src   <= sel;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef FILTER_INST_ARB_PERF_CNT_EN
  // Wrapping per-requester packet counters and completed-burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt   <= '0;
      burst_cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < NREQ; i++) begin
        if (sel == SRC_W'(i)) pkt_cnt[i*16 +: 16] <= pkt_cnt[i*16 +: 16] + 16'd1;
      end
      if (acc_last) burst_cnt <= burst_cnt + 16'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule
